// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, issues same-cycle word reads and buffers
// {pc, instr} pairs for decode behind a valid/ready handshake. Redirects flush the buffer.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc;
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          pop, fetch;

    // Reset and redirect both hide the head so nothing is handed off in those cycles.
    assign out_valid = (count != '0) & ~redirect_valid & ~rst;
    assign pop       = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full buffer keeps streaming.
    assign fetch     = ~rst & ~redirect_valid & ((count - CW'(pop)) < CW'(DEPTH));

    assign mem_re    = fetch;
    assign mem_addr  = {2'b00, pc[31:2]};
    assign out_instr = buf_instr[rd_ptr];
    assign out_pc    = buf_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch) begin
                buf_pc[wr_ptr]    <= pc;
                buf_instr[wr_ptr] <= mem_rdata;
                wr_ptr            <= wr_ptr + PW'(1);
                pc                <= pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(fetch) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory word at word address a holds 32'h1000_0000 + a.
module tb_instr_fetch;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = 32'h1000_0000 + mem_addr;

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    // Inputs are driven 2 time units after the rising edge; checks follow 1 unit later.
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench in cycle 0 (first cycle with rst low), inputs not yet settled.
    task automatic do_reset(input logic rdy);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = rdy;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        nxt();
        nxt();
        #1;
        assertions++; if (mem_re !== 1'b0) begin failures++; $display("FAIL rst_mem_re got %b exp 0", mem_re); end
        assertions++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        assertions++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rst_out_pc got %h exp 0", out_pc); end
        assertions++; if (out_instr !== 32'h0) begin failures++; $display("FAIL rst_out_instr got %h exp 0", out_instr); end
        rst = 1'b0;
        #1;
        assertions++; if (mem_re !== 1'b1) begin failures++; $display("FAIL c0_mem_re got %b exp 1", mem_re); end
        assertions++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL c0_mem_addr got %h exp 0", mem_addr); end
        assertions++; if (out_valid !== 1'b0) begin failures++; $display("FAIL c0_out_valid got %b exp 0", out_valid); end
        for (int i = 1; i <= 10; i++) begin
            nxt();
            #1;
            assertions++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid c%0d got %b exp 1", i, out_valid); end
            assertions++; if (out_pc !== 32'(4 * (i - 1))) begin failures++; $display("FAIL stream_pc c%0d got %h exp %h", i, out_pc, 32'(4 * (i - 1))); end
            assertions++; if (out_instr !== 32'h1000_0000 + 32'(i - 1)) begin failures++; $display("FAIL stream_instr c%0d got %h exp %h", i, out_instr, 32'h1000_0000 + 32'(i - 1)); end
            assertions++; if (mem_re !== 1'b1) begin failures++; $display("FAIL stream_mem_re c%0d got %b exp 1", i, mem_re); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin nxt(); #1; end
            assertions++; if (mem_re !== (i < D)) begin failures++; $display("FAIL bp_mem_re c%0d got %b exp %b", i, mem_re, (i < D)); end
            if (i > 0) begin
                assertions++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL bp_head c%0d got v=%b pc=%h exp v=1 pc=0", i, out_valid, out_pc); end
            end
        end
        for (int i = 0; i < 6; i++) begin
            nxt();
            out_ready = 1'b1;
            #1;
            assertions++; if (mem_re !== 1'b1) begin failures++; $display("FAIL bp_rel_mem_re k%0d got %b exp 1", i, mem_re); end
            assertions++; if (mem_addr !== 32'(D + i)) begin failures++; $display("FAIL bp_rel_addr k%0d got %h exp %h", i, mem_addr, 32'(D + i)); end
            assertions++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin failures++; $display("FAIL bp_rel_pc k%0d got v=%b pc=%h exp pc=%h", i, out_valid, out_pc, 32'(4 * i)); end
            assertions++; if (out_instr !== 32'h1000_0000 + 32'(i)) begin failures++; $display("FAIL bp_rel_instr k%0d got %h exp %h", i, out_instr, 32'h1000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_full_pop();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) nxt();
        out_ready = 1'b1;
        #1;
        assertions++; if (mem_re !== 1'b1) begin failures++; $display("FAIL fp_mem_re got %b exp 1", mem_re); end
        assertions++; if (out_pc !== 32'h0) begin failures++; $display("FAIL fp_head got %h exp 0", out_pc); end
        nxt();
        out_ready = 1'b0;
        #1;
        assertions++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin failures++; $display("FAIL fp_next got v=%b pc=%h exp pc=4", out_valid, out_pc); end
        assertions++; if (mem_re !== 1'b0) begin failures++; $display("FAIL fp_still_full got mem_re=%b exp 0", mem_re); end
        nxt();
        out_ready = 1'b1;
        #1;
        assertions++; if (out_pc !== 32'h4 || mem_re !== 1'b1 || mem_addr !== 32'(D + 1)) begin failures++; $display("FAIL fp_resume got pc=%h re=%b addr=%h exp pc=4 re=1 addr=%h", out_pc, mem_re, mem_addr, 32'(D + 1)); end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) nxt();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        assertions++; if (mem_addr !== 32'h8) begin failures++; $display("FAIL rd_pre_addr got %h exp 8", mem_addr); end
        assertions++; if (out_valid !== 1'b0 || mem_re !== 1'b0) begin failures++; $display("FAIL rd_n got v=%b re=%b exp 0 0", out_valid, mem_re); end
        nxt();
        redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        assertions++; if (out_valid !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 32'h40) begin failures++; $display("FAIL rd_n1 got v=%b re=%b addr=%h exp 0 1 40", out_valid, mem_re, mem_addr); end
        for (int i = 0; i < 4; i++) begin
            nxt();
            #1;
            assertions++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL rd_pc k%0d got v=%b pc=%h exp %h", i, out_valid, out_pc, 32'h100 + 32'(4 * i)); end
            assertions++; if (out_instr !== 32'h1000_0040 + 32'(i)) begin failures++; $display("FAIL rd_instr k%0d got %h exp %h", i, out_instr, 32'h1000_0040 + 32'(i)); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_ad [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        exp_ad[0] = 32'h3FFF_FFFE; exp_ad[1] = 32'h3FFF_FFFF; exp_ad[2] = 32'h0;
        nxt();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
        nxt();
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        assertions++; if (mem_re !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap got re=%b v=%b exp 0 0", mem_re, out_valid); end
        nxt();
        redirect_valid = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt();
            #1;
            if (i < 3) begin
                assertions++; if (mem_re !== 1'b1 || mem_addr !== exp_ad[i]) begin failures++; $display("FAIL wrap_addr k%0d got re=%b addr=%h exp %h", i, mem_re, mem_addr, exp_ad[i]); end
            end
            if (i > 0) begin
                assertions++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i-1]) begin failures++; $display("FAIL wrap_pc k%0d got v=%b pc=%h exp %h", i, out_valid, out_pc, exp_pc[i-1]); end
                assertions++; if (out_instr !== 32'h1000_0000 + {2'b00, exp_pc[i-1][31:2]}) begin failures++; $display("FAIL wrap_instr k%0d got %h", i, out_instr); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) nxt();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        #1;
        assertions++; if (mem_re !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rm_during got re=%b v=%b exp 0 0", mem_re, out_valid); end
        nxt();
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        #1;
        assertions++; if (out_valid !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL rm_restart got v=%b re=%b addr=%h exp 0 1 0", out_valid, mem_re, mem_addr); end
        for (int i = 0; i < 2; i++) begin
            nxt();
            #1;
            assertions++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin failures++; $display("FAIL rm_pc k%0d got v=%b pc=%h exp %h", i, out_valid, out_pc, 32'(4 * i)); end
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_full_pop();
        test_redirect();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator side of the instruction memory read port. Holds the program counter and issues same-cycle word reads to the instruction memory (combinational read data while read enable is high). Captures each word with its PC in a 2-entry buffer and hands it to decode over a valid/ready handshake. Accepts a branch/jump redirect that flushes buffered instructions.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- DEPTH, 2, buffer entries; legal values 2 and 4

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mem_addr  out  32  word address to instruction memory = {2'b00, pc[31:2]}
- mem_re  out  1  read enable; high on every cycle a fetch is issued
- mem_rdata  in  32  instruction word; valid in the same cycle as mem_re
- redirect_valid  in  1  load a new PC this cycle
- redirect_pc  in  32  redirect target byte address; bits [1:0] ignored (forced 0)
- out_valid  out  1  buffer head holds an instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  instruction at buffer head
- out_pc  out  32  byte PC of out_instr

## Operation
- State: pc (32 b), circular buffer of DEPTH {pc, instr} entries, read pointer, write pointer, count (0..DEPTH).
- pop = out_valid & out_ready.
- out_valid = (count != 0) & ~redirect_valid. No instruction is accepted in a redirect cycle.
- fetch = ~rst & ~redirect_valid & ((count - pop) < DEPTH). A full buffer with a pop still fetches in that cycle.
- mem_re = fetch. When fetch is 0, mem_addr still shows the current pc.
- On a fetch cycle, at the posedge:
  - Push {pc, mem_rdata}.
  - pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - count <= count + 1 - pop.
- Simultaneous push and pop: count unchanged, both pointers advance.
- On a redirect cycle, at the posedge:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - count, rd ptr and wr ptr are cleared.
  - No push and no pop.
  - Redirect takes priority over any fetch or handshake.
- out_instr and out_pc come from the head entry. Their value is don't-care when out_valid = 0 and must not be checked.
- Buffer contents are stable while out_valid & ~out_ready: head does not change and no entry is overwritten.

## Timing
- Reset (rst = 1 at a posedge):
  - pc = RESET_PC; count = 0; pointers = 0.
  - out_valid = 0, mem_re = 0 while rst is high.
  - out_instr and out_pc reset to 0.
- rst asserted mid-stream discards all buffered instructions. It overrides redirect_valid.
- First cycle after reset (cycle 0): mem_re = 1, mem_addr = RESET_PC >> 2.
- Cycle 1: out_valid = 1, out_pc = RESET_PC.
- Fetch-to-decode latency: 1 cycle.
- Sustained throughput with out_ready held high: 1 instruction per cycle.
- Backpressure: with out_ready low, fetches continue until count = DEPTH, then mem_re drops. A pop restores fetching in the same cycle.
- Redirect asserted in cycle N:
  - Cycle N: out_valid = 0, mem_re = 0.
  - Cycle N+1: mem_re = 1 at the target; out_valid = 0.
  - Cycle N+2: out_valid = 1 with out_pc = target.
- Back-to-back redirects: the last one wins; no fetch occurs between them.
- No combinational path from mem_rdata to any output.
- Combinational paths from out_ready and redirect_valid to mem_re are permitted.

## Test plan
- Reset and stream:
  - Stimulus: memory word i = 32'h1000_0000 + i, RESET_PC = 0, out_ready = 1, run 10 cycles after rst drops.
  - Required: accepted pairs (out_pc, out_instr) = (0, 32'h1000_0000), (4, 32'h1000_0001), … consecutively from cycle 1; mem_re low during rst.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles, then 1.
  - Required: mem_re high for exactly DEPTH cycles, then low; no PC skipped or duplicated after release; head holds PC 0 throughout the stall.
- Full with simultaneous pop:
  - Stimulus: count = DEPTH, out_ready pulsed for 1 cycle.
  - Required: mem_re = 1 in that cycle; count stays DEPTH; next out_pc = previous head + 4.
- Redirect:
  - Stimulus: while streaming at pc 0x20, pulse redirect_valid with redirect_pc = 32'h0000_0103.
  - Required: out_valid low for 2 cycles; next accepted out_pc = 0x100; no stale instruction from 0x1C–0x24 is accepted afterwards.
- Wrap-around:
  - Stimulus: redirect_pc = 32'hFFFF_FFF8.
  - Required: accepted PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000; mem_addr = 3FFF_FFFE, 3FFF_FFFF, 0.
- Reset mid-operation:
  - Stimulus: rst for 1 cycle with count = 2 and redirect_valid = 1 in the same cycle.
  - Required: count = 0; fetch restarts at RESET_PC (not the redirect target); first accepted out_pc = RESET_PC.
